rom_lector: RTL and testbench

Address sequencer and read stage that sits directly upstream of the combinational `rom`. On a start pulse it sweeps `direccion` from a start address to an end address, one word per accepted transfer. It wraps past 255 when needed. Each ROM word (`dato_s` of the ROM) is captured into a registered output with a valid/ready handshake toward the consumer.

---
 rtl/rom_pkg.sv | 18 +
 rtl/etapa_salida.sv | 33 +++
 rtl/rom.sv | 18 +
 rtl/rom_lector.sv | 106 ++++++++++
 tb/tb_rom_lector.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM and its address sequencer: default widths
// and the sequencer state encoding.
package rom_pkg;

    localparam int ANCHO_DIR_DEF  = 8;
    localparam int ANCHO_DATO_DEF = 8;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] LEYENDO  = 2'd1;
    localparam logic [1:0] VACIANDO = 2'd2;

    typedef enum logic [1:0] {
        EST_REPOSO   = REPOSO,
        EST_LEYENDO  = LEYENDO,
        EST_VACIANDO = VACIANDO
    } estado_t;

endpackage

// File: rtl/etapa_salida.sv
// Registered output word with valid/ready handshake; clear has priority over
// load so a cancel always empties the stage.
module etapa_salida
    import rom_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cargar,
    input  logic                  limpiar,
    input  logic                  listo,
    input  logic [ANCHO_DATO-1:0] dato_in,
    output logic [ANCHO_DATO-1:0] dato_s,
    output logic                  valido,
    output logic                  puede_cargar
);

    assign puede_cargar = !valido || listo;

    always_ff @(posedge clk) begin
        if (rst) begin
            dato_s <= '0;
            valido <= 1'b0;
        end else if (limpiar) begin
            valido <= 1'b0;
        end else if (cargar) begin
            dato_s <= dato_in;
            valido <= 1'b1;
        end
    end

endmodule

// File: rtl/rom.sv
// Combinational lookup ROM: each word is the nibble-swapped address XOR 0x5A,
// so every address maps to a distinct word.
module rom
    import rom_pkg::*;
#(
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
    input  logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] dato_s
);

    logic [ANCHO_DIR-1:0] girada;

    assign girada = {direccion[ANCHO_DIR/2-1:0], direccion[ANCHO_DIR-1:ANCHO_DIR/2]};
    assign dato_s = ANCHO_DATO'(girada ^ ANCHO_DIR'(8'h5A));

endmodule

// File: rtl/rom_lector.sv
// Address sequencer in front of the combinational ROM: sweeps dir_ini..dir_fin
// (wrapping modulo 2^ANCHO_DIR) and hands each word to the consumer.
module rom_lector
    import rom_pkg::*;
#(
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic                  abortar,
    input  logic [ANCHO_DIR-1:0]  dir_ini,
    input  logic [ANCHO_DIR-1:0]  dir_fin,
    output logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_DATO-1:0] dato_rom,
    output logic [ANCHO_DATO-1:0] dato_s,
    output logic                  valido,
    input  logic                  listo,
    output logic                  ocupado,
    output logic                  fin
);

    localparam logic [ANCHO_DIR-1:0] UNO = ANCHO_DIR'(1);

    estado_t               estado_q, estado_d;
    logic [ANCHO_DIR-1:0]  dir_d;
    logic [ANCHO_DIR-1:0]  dir_fin_q, dir_fin_d;
    logic                  fin_d;
    logic                  cargar, limpiar, puede_cargar;

    etapa_salida #(.ANCHO_DATO(ANCHO_DATO)) u_etapa (
        .clk          (clk),
        .rst          (rst),
        .cargar       (cargar),
        .limpiar      (limpiar),
        .listo        (listo),
        .dato_in      (dato_rom),
        .dato_s       (dato_s),
        .valido       (valido),
        .puede_cargar (puede_cargar)
    );

    assign ocupado = (estado_q != EST_REPOSO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= EST_REPOSO;
            direccion <= '0;
            dir_fin_q <= '0;
            fin       <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            direccion <= dir_d;
            dir_fin_q <= dir_fin_d;
            fin       <= fin_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        dir_d     = direccion;
        dir_fin_d = dir_fin_q;
        fin_d     = 1'b0;
        cargar    = 1'b0;
        limpiar   = 1'b0;
        case (estado_q)
            EST_REPOSO: begin
                // abortar is meaningless here, so inicio alone decides.
                if (inicio) begin
                    dir_d     = dir_ini;
                    dir_fin_d = dir_fin;
                    estado_d  = EST_LEYENDO;
                end
            end
            EST_LEYENDO: begin
                if (abortar) begin
                    limpiar  = 1'b1;
                    estado_d = EST_REPOSO;
                end else if (puede_cargar) begin
                    cargar = 1'b1;
                    if (direccion == dir_fin_q) begin
                        estado_d = EST_VACIANDO;
                    end else begin
                        dir_d = direccion + UNO;
                    end
                end
            end
            EST_VACIANDO: begin
                if (abortar) begin
                    limpiar  = 1'b1;
                    estado_d = EST_REPOSO;
                end else if (valido && listo) begin
                    limpiar  = 1'b1;
                    fin_d    = 1'b1;
                    estado_d = EST_REPOSO;
                end
            end
            default: begin
                limpiar  = 1'b1;
                estado_d = EST_REPOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_lector.sv
// Self-checking bench for rom_lector driving the real rom: table of sweeps,
// random sweeps with random backpressure, and hand-written abort/reset cases.
module tb_rom_lector;

    logic       clk = 1'b0;
    logic       rst, inicio, abortar, listo;
    logic [7:0] dir_ini, dir_fin, direccion, dato_rom, dato_s;
    logic       valido, ocupado, fin;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] ini;
        logic [7:0] dfin;
        int         modo;   // 1 listo=1, 2 listo low on cycles 3-5, 3 random listo, 4 inicio+abortar
        int         n;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    rom #(.ANCHO_DIR(8), .ANCHO_DATO(8)) u_rom (
        .direccion (direccion),
        .dato_s    (dato_rom)
    );

    rom_lector #(.ANCHO_DIR(8), .ANCHO_DATO(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .abortar   (abortar),
        .dir_ini   (dir_ini),
        .dir_fin   (dir_fin),
        .direccion (direccion),
        .dato_rom  (dato_rom),
        .dato_s    (dato_s),
        .valido    (valido),
        .listo     (listo),
        .ocupado   (ocupado),
        .fin       (fin)
    );

    function automatic logic [7:0] rom_ref(input int a);
        int b;
        b = a % 256;
        return 8'(((b % 16) * 16 + b / 16) ^ 90);
    endfunction

    function automatic int sweep_len(input int ini, input int dfin);
        if (dfin >= ini) return dfin - ini + 1;
        return 256 - ini + dfin + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_sweep(input vec_t v);
        logic [7:0] got[$];
        logic       prev_hold;
        logic [7:0] prev_dato, prev_dir;
        int         e, fall_e, budget;
        got.delete();
        budget    = 4 * v.n + 20;
        prev_hold = 1'b0;
        prev_dato = '0;
        prev_dir  = '0;
        fall_e    = -1;
        dir_ini   = v.ini;
        dir_fin   = v.dfin;
        inicio    = 1'b1;
        abortar   = (v.modo == 4);
        listo     = 1'b1;
        tick;
        inicio  = 1'b0;
        abortar = 1'b0;
        e = 1;
        while (e <= budget) begin
            if (prev_hold) begin
                chk("hold_valido", valido, 1);
                chk("hold_dato", dato_s, prev_dato);
                chk("hold_dir", direccion, prev_dir);
            end
            if (e == 1) begin
                chk("e1_direccion", direccion, v.ini);
                chk("e1_ocupado", ocupado, 1);
                chk("e1_valido", valido, 0);
            end
            if (e == 2) begin
                chk("e2_valido", valido, 1);
                chk("e2_dato", dato_s, rom_ref(v.ini));
            end
            if (!ocupado) begin
                fall_e = e;
                chk("fin_at_end", fin, 1);
                chk("valido_at_end", valido, 0);
                break;
            end
            chk("fin_low_busy", fin, 0);
            case (v.modo)
                2:       listo = !(e >= 3 && e <= 5);
                3:       listo = ($urandom_range(0, 3) != 0);
                default: listo = 1'b1;
            endcase
            if (v.modo == 3 && e == 3) begin
                inicio  = 1'b1;
                dir_ini = v.ini + 8'd50;
                dir_fin = v.ini + 8'd51;
            end
            if (valido && listo) got.push_back(dato_s);
            prev_hold = valido && !listo;
            prev_dato = dato_s;
            prev_dir  = direccion;
            tick;
            inicio = 1'b0;
            e++;
        end
        if (fall_e < 0) chk("timeout", 0, 1);
        if (v.modo == 1 || v.modo == 4) chk("ocupado_fall_edge", fall_e, v.n + 2);
        chk("n_words", got.size(), v.n);
        for (int i = 0; i < got.size() && i < v.n; i++) begin
            chk("word", got[i], rom_ref(v.ini + i));
        end
        tick;
        chk("fin_one_cycle", fin, 0);
        chk("idle_ocupado", ocupado, 0);
    endtask

    initial begin
        logic [7:0] dir_hold;
        vec_t       v;
        rst     = 1'b1;
        inicio  = 1'b0;
        abortar = 1'b0;
        listo   = 1'b0;
        dir_ini = '0;
        dir_fin = '0;
        tick;
        tick;
        chk("rst_direccion", direccion, 0);
        chk("rst_dato", dato_s, 0);
        chk("rst_valido", valido, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_fin", fin, 0);
        rst = 1'b0;
        tick;

        tbl.push_back('{ini: 8'd0,   dfin: 8'd4,   modo: 1, n: 5});
        tbl.push_back('{ini: 8'd0,   dfin: 8'd4,   modo: 2, n: 5});
        tbl.push_back('{ini: 8'd254, dfin: 8'd1,   modo: 1, n: 4});
        tbl.push_back('{ini: 8'd7,   dfin: 8'd7,   modo: 1, n: 1});
        tbl.push_back('{ini: 8'd0,   dfin: 8'd255, modo: 1, n: 256});
        tbl.push_back('{ini: 8'd20,  dfin: 8'd25,  modo: 4, n: 6});
        for (int i = 0; i < 6; i++) begin
            v.ini  = 8'($urandom_range(0, 255));
            v.dfin = 8'($urandom_range(0, 255));
            v.modo = 3;
            v.n    = sweep_len(v.ini, v.dfin);
            tbl.push_back(v);
        end
        foreach (tbl[i]) run_sweep(tbl[i]);

        // abort after two transfers of a 0..9 sweep
        dir_ini = 8'd0;
        dir_fin = 8'd9;
        inicio  = 1'b1;
        listo   = 1'b1;
        tick;
        inicio = 1'b0;
        tick;
        tick;
        tick;
        chk("abort_pre_dato", dato_s, rom_ref(2));
        chk("abort_pre_dir", direccion, 3);
        dir_hold = direccion;
        abortar  = 1'b1;
        listo    = 1'b0;
        tick;
        abortar = 1'b0;
        chk("abort_valido", valido, 0);
        chk("abort_ocupado", ocupado, 0);
        chk("abort_fin", fin, 0);
        chk("abort_dir_hold", direccion, dir_hold);
        tick;
        chk("abort_no_fin", fin, 0);
        run_sweep('{ini: 8'd3, dfin: 8'd5, modo: 1, n: 3});

        // reset in the middle of a sweep
        dir_ini = 8'd10;
        dir_fin = 8'd20;
        inicio  = 1'b1;
        listo   = 1'b1;
        tick;
        inicio = 1'b0;
        repeat (4) tick;
        chk("pre_rst_busy", ocupado, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_direccion", direccion, 0);
        chk("midrst_dato", dato_s, 0);
        chk("midrst_valido", valido, 0);
        chk("midrst_ocupado", ocupado, 0);
        chk("midrst_fin", fin, 0);
        tick;
        run_sweep('{ini: 8'd100, dfin: 8'd102, modo: 2, n: 3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
